// File: rtl/rxecrc_strip.sv
// rxecrc_strip: receive-path FCS checker and stripper.
// Sits after the preamble/SFD stripper. Runs the reflected CRC-32 over every
// byte of a frame, holds the last four bytes back in a delay line so the FCS is
// never forwarded, and pulses o_err once per frame whose FCS is bad or missing.
// With i_en=0 the stage is a one-ce-cycle transparent register.
module rxecrc_strip (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_ce,
  input  logic       i_en,
  input  logic       i_v,
  input  logic [7:0] i_d,
  output logic       o_v,
  output logic [7:0] o_d,
  output logic       o_err
);

  // Reflected IEEE 802.3 polynomial, seed and the register value left behind
  // by a frame whose own FCS has been run through the LFSR.
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [2:0]  FILL_FULL   = 3'd4;

  // ST_FRAME means the previous ce cycle accepted a byte, so an i_v=0 ce cycle
  // in this state is the end-of-frame cycle.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] crc_reg, crc_next;
  logic [2:0]  fill_reg, fill_next;
  logic [7:0]  dly_reg [4];
  logic        shift_en;
  logic        full;
  logic        ov_next;
  logic [7:0]  od_next;
  logic        err_next;

  // Eight-step unrolled LFSR: crc_step[0] is the register with the byte folded
  // into its low bits, crc_step[8] is the whole-byte result.
  logic [31:0] crc_step [9];

  assign crc_step[0] = crc_reg ^ {24'h000000, i_d};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
      assign crc_step[gi+1] = crc_step[gi][0] ? ((crc_step[gi] >> 1) ^ CRC_POLY)
                                              :  (crc_step[gi] >> 1);
    end
  endgenerate

  // Four bytes already held means the oldest one is payload, not FCS.
  assign full = (fill_reg == FILL_FULL);

  // Next-state and next-output logic for one ce cycle.
  always_comb begin
    state_next = state_reg;
    crc_next   = crc_reg;
    fill_next  = fill_reg;
    shift_en   = 1'b0;
    ov_next    = 1'b0;
    od_next    = 8'h00;
    err_next   = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (i_v) begin
          state_next = ST_FRAME;
        end
      end
      ST_FRAME: begin
        if (!i_v) begin
          state_next = ST_IDLE;
          // Verdict on the frame that just ended; suppressed in pass-through.
          err_next   = i_en && (!full || (crc_reg != CRC_RESIDUE));
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (i_v) begin
      crc_next  = crc_step[8];
      shift_en  = 1'b1;
      fill_next = full ? fill_reg : (fill_reg + 3'd1);
      if (i_en) begin
        ov_next = full;
        od_next = full ? dly_reg[3] : 8'h00;
      end else begin
        ov_next = 1'b1;
        od_next = i_d;
      end
    end else begin
      // Gap and idle cycles keep the checker primed for the next frame.
      crc_next  = CRC_INIT;
      fill_next = 3'd0;
    end
  end

  // State, CRC and fill registers advance only on enabled cycles.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= ST_IDLE;
      crc_reg   <= CRC_INIT;
      fill_reg  <= 3'd0;
    end else if (i_ce) begin
      state_reg <= state_next;
      crc_reg   <= crc_next;
      fill_reg  <= fill_next;
    end
  end

  // Delay line: stage 0 takes the new byte, stage 3 holds the oldest one.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dly
      if (gi == 0) begin : g_head
        // Head stage captures the accepted input byte.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
          if (!i_reset_n) begin
            dly_reg[0] <= 8'h00;
          end else if (i_ce && shift_en) begin
            dly_reg[0] <= i_d;
          end
        end
      end else begin : g_tail
        // Later stages shift from the previous stage.
        always_ff @(posedge i_clk or negedge i_reset_n) begin
          if (!i_reset_n) begin
            dly_reg[gi] <= 8'h00;
          end else if (i_ce && shift_en) begin
            dly_reg[gi] <= dly_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  // Registered outputs, held between enabled cycles.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_v   <= 1'b0;
      o_d   <= 8'h00;
      o_err <= 1'b0;
    end else if (i_ce) begin
      o_v   <= ov_next;
      o_d   <= od_next;
      o_err <= err_next;
    end
  end

endmodule

// File: tb/tb_rxecrc_strip.sv
// Randomized self-checking bench for rxecrc_strip against a frame-level model.
module tb_rxecrc_strip;

  typedef logic [7:0] bq_t [$];

  logic       clk;
  logic       rst_n;
  logic       ce;
  logic       en;
  logic       v;
  logic [7:0] d;
  logic       o_v;
  logic [7:0] o_d;
  logic       o_err;

  int checks = 0;
  int errors = 0;

  bq_t        got_q;
  int         err_seen;
  int         ce_mode;
  logic       ce_s;
  logic [9:0] prev_out;

  rxecrc_strip dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_ce      (ce),
    .i_en      (en),
    .i_v       (v),
    .i_d       (d),
    .o_v       (o_v),
    .o_d       (o_d),
    .o_err     (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Standard CRC-32 (seed all ones, final inversion) of the first n bytes.
  function automatic logic [31:0] crc32(input bq_t f, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, f[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Append the FCS, least significant byte first.
  function automatic bq_t with_fcs(input bq_t f);
    logic [31:0] c;
    bq_t r;
    c = crc32(f, f.size());
    r = f;
    r.push_back(c[7:0]);
    r.push_back(c[15:8]);
    r.push_back(c[23:16]);
    r.push_back(c[31:24]);
    return r;
  endfunction

  // A frame is good iff it has an FCS and its last four bytes are the CRC of the rest.
  function automatic int model_err(input bq_t f, input logic enb);
    int n;
    logic [31:0] fcs;
    n = f.size();
    if (!enb) return 0;
    if (n < 4) return 1;
    fcs = {f[n-1], f[n-2], f[n-3], f[n-4]};
    return (fcs != crc32(f, n - 4)) ? 1 : 0;
  endfunction

  function automatic bq_t model_out(input bq_t f, input logic enb);
    bq_t r;
    if (!enb) return f;
    for (int i = 0; i < f.size() - 4; i++) r.push_back(f[i]);
    return r;
  endfunction

  // Observe outputs just after every edge: collect bytes on ce edges,
  // insist on held outputs across non-ce edges.
  always @(posedge clk) begin
    ce_s = ce;
    #1;
    if (ce_s) begin
      if (o_v) got_q.push_back(o_d);
      else check_val("od_zero_when_not_valid", 32'(o_d), 32'h0);
      if (o_err) err_seen++;
    end else begin
      check_val("hold_without_ce", 32'({o_v, o_d, o_err}), 32'(prev_out));
    end
    prev_out = {o_v, o_d, o_err};
  end

  task automatic ce_cycle(input logic vv, input logic [7:0] dd);
    int skip;
    case (ce_mode)
      0:       skip = 0;
      1:       skip = 3;
      default: skip = $urandom_range(0, 2);
    endcase
    repeat (skip) begin
      @(negedge clk);
      ce = 1'b0;
      v  = 1'($urandom);
      d  = 8'($urandom);
    end
    @(negedge clk);
    ce = 1'b1;
    v  = vv;
    d  = dd;
  endtask

  task automatic send(input bq_t f, input int gap);
    foreach (f[i]) ce_cycle(1'b1, f[i]);
    repeat (gap) ce_cycle(1'b0, 8'h00);
  endtask

  task automatic finish_check(input string tag, input bq_t exp, input int exp_err);
    @(posedge clk);
    #2;
    check_val({tag, "_len"}, 32'(got_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      check_val({tag, "_byte"}, 32'(got_q[i]), 32'(exp[i]));
    check_val({tag, "_err"}, 32'(err_seen), 32'(exp_err));
    $display("frame %s: en=%0b mode=%0d out=%0d/%0d err=%0d/%0d",
             tag, en, ce_mode, got_q.size(), exp.size(), err_seen, exp_err);
    got_q.delete();
    err_seen = 0;
  endtask

  initial begin
    bq_t good, bad, runt3, runt4, f, exp, rem;
    int  n, gap;

    rst_n = 1'b0; ce = 1'b0; en = 1'b1; v = 1'b0; d = 8'h00;
    ce_mode = 0; err_seen = 0; prev_out = '0;
    good  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
    bad   = good;
    bad[12] = 8'hCA;
    runt3 = '{8'hAA, 8'hBB, 8'hCC};
    runt4 = '{8'h26, 8'h39, 8'hF4, 8'hCB};

    repeat (3) @(negedge clk);
    check_val("reset_o_v", 32'(o_v), 32'h0);
    check_val("reset_o_d", 32'(o_d), 32'h0);
    check_val("reset_o_err", 32'(o_err), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    got_q.delete();
    err_seen = 0;

    // Directed frames at full byte rate.
    send(good, 2);  finish_check("good", model_out(good, 1'b1), model_err(good, 1'b1));
    send(bad, 2);   finish_check("bad_fcs", model_out(bad, 1'b1), model_err(bad, 1'b1));
    send(runt3, 2); finish_check("runt3", model_out(runt3, 1'b1), model_err(runt3, 1'b1));
    send(runt4, 2); finish_check("runt4", model_out(runt4, 1'b1), model_err(runt4, 1'b1));

    // Sparse clock enable.
    ce_mode = 1;
    send(good, 2);  finish_check("good_ce4", model_out(good, 1'b1), 0);
    ce_mode = 0;

    // Back-to-back frames with a single gap cycle.
    send(good, 1);
    send(good, 2);
    exp = {model_out(good, 1'b1), model_out(good, 1'b1)};
    finish_check("back_to_back", exp, 0);

    // Transparent mode.
    en = 1'b0;
    send(good, 2);  finish_check("passthru", good, 0);
    en = 1'b1;

    // Asynchronous reset while the sixth byte is presented.
    for (int i = 0; i < good.size(); i++) begin
      @(negedge clk);
      ce = 1'b1; v = 1'b1; d = good[i];
      if (i == 5) begin
        check_val("pre_reset_o_v", 32'(o_v), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_reset_o_v", 32'(o_v), 32'h0);
        check_val("async_reset_o_d", 32'(o_d), 32'h0);
        check_val("async_reset_o_err", 32'(o_err), 32'h0);
        got_q.delete();
        err_seen = 0;
        #1 rst_n = 1'b1;
      end
    end
    repeat (2) ce_cycle(1'b0, 8'h00);
    rem = good[5:12];
    finish_check("after_reset", model_out(rem, 1'b1), model_err(rem, 1'b1));

    // Randomized frames, enables and ce patterns.
    for (int t = 0; t < 40; t++) begin
      ce_mode = $urandom_range(0, 2);
      en      = ($urandom_range(0, 3) != 0);
      n       = $urandom_range(1, 20);
      f.delete();
      if (n >= 5 && $urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n - 4; i++) f.push_back(8'($urandom));
        f = with_fcs(f);
      end else begin
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
      end
      gap = $urandom_range(1, 3);
      send(f, gap);
      finish_check($sformatf("rand%0d", t), model_out(f, en), model_err(f, en));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
